// File: rtl/hex_display_arbiter.sv
// Round-robin owner of the six-digit HEX display with a minimum hold time before preemption.
// Optional HEXARB_IDLE_BLANK_EN: while idle, the display is darkened (hex_out = 0, blank = 1).
module hex_display_arbiter #(
    parameter int unsigned HOLD_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  req,
    input  logic [23:0] data0,
    input  logic [23:0] data1,
    input  logic [23:0] data2,
    input  logic [23:0] data3,
    output logic [3:0]  grant,
    output logic [1:0]  owner,
    output logic        busy,
    output logic [23:0] hex_out,
    output logic        blank
);

    localparam int DATA_W = 24;
    localparam int CNT_W  = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t              state, state_d;
    logic [3:0]          grant_d;
    logic [1:0]          owner_d;
    logic [1:0]          last, last_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic                busy_d;
    logic [DATA_W-1:0]   hex_d;
    logic [DATA_W-1:0]   data_sel;
    logic [2:0]          pick_idle, pick_pre;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= HOLD_MAX) ? HOLD_MAX : v + CNT_W'(1);
    endfunction

    // Returns {found, index} of the first set bit scanning base+1, base+2, ... cyclically.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [2:0] pick;
        logic [1:0] idx;
        pick = 3'b000;
        for (int i = 1; i <= 4; i++) begin
            idx = base + 2'(i);
            if (r[idx] && !pick[2])
                pick = {1'b1, idx};
        end
        return pick;
    endfunction

    assign pick_idle = rr_pick(req, last);
    assign pick_pre  = rr_pick(req & ~(4'b0001 << owner), owner);

    always_comb begin
        data_sel = data0;
        case (owner)
            2'd0: data_sel = data0;
            2'd1: data_sel = data1;
            2'd2: data_sel = data2;
            2'd3: data_sel = data3;
        endcase
    end

    always_comb begin
        state_d = state;
        grant_d = grant;
        owner_d = owner;
        last_d  = last;
        cnt_d   = cnt;
        hex_d   = hex_out;
        case (state)
            IDLE: begin
                if (pick_idle[2]) begin
                    state_d = OWNED;
                    grant_d = 4'b0001 << pick_idle[1:0];
                    owner_d = pick_idle[1:0];
                    last_d  = pick_idle[1:0];
                    cnt_d   = '0;
                end
            end
            OWNED: begin
                hex_d = data_sel;
                // A release always beats a pending preemption.
                if (!req[owner]) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if (cnt == HOLD_MAX && pick_pre[2]) begin
                    grant_d = 4'b0001 << pick_pre[1:0];
                    owner_d = pick_pre[1:0];
                    last_d  = pick_pre[1:0];
                    cnt_d   = '0;
                end else begin
                    cnt_d = sat_inc(cnt);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == OWNED);
`ifdef HEXARB_IDLE_BLANK_EN
        if (state_d == IDLE)
            hex_d = '0;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            grant   <= '0;
            owner   <= '0;
            last    <= 2'd3;
            cnt     <= '0;
            busy    <= 1'b0;
            hex_out <= '0;
        end else begin
            state   <= state_d;
            grant   <= grant_d;
            owner   <= owner_d;
            last    <= last_d;
            cnt     <= cnt_d;
            busy    <= busy_d;
            hex_out <= hex_d;
        end
    end

`ifdef HEXARB_IDLE_BLANK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            blank <= 1'b1;
        else
            blank <= (state_d == IDLE);
    end
`else
    assign blank = 1'b0;
`endif

endmodule

// File: doc/hex_display_arbiter.md
# hex_display_arbiter

Shares the six-digit HEX display between up to four requesters, for example the Nios PIO `hex_export` word and hardware CRC result sources. Each requester supplies a 24-bit value (six nibbles). The block grants one requester at a time using round-robin order and enforces a minimum display hold time. It sits between the requesters and the six hexdecoder instances and drives their 24-bit input.

## Interface
Parameters:
- `HOLD_CYCLES`, default 50_000_000. Minimum number of cycles an owner keeps the display before another requester may preempt it. Legal range is 1 to 2^26-1.

Ports:
- `clk`, input, 1. System clock (CLOCK_50 domain).
- `reset_n`, input, 1. Asynchronous, active-low reset.
- `req`, input, 4. Display request, one bit per requester; level-sensitive.
- `data0`, `data1`, `data2`, `data3`, input, 24 each. Value per requester; nibble [3:0] drives HEX0 and nibble [23:20] drives HEX5.
- `grant`, output, 4. One-hot ownership indication; all zero when idle.
- `owner`, output, 2. Index of the current or last owner.
- `busy`, output, 1. High while any grant is active.
- `hex_out`, output, 24. Registered display word to the hexdecoders.
- `blank`, output, 1. High when the display should be dark. Meaningful only with the macro enabled.

## Operation
- The FSM has two states, IDLE and OWNED. An internal hold counter is sized to hold `HOLD_CYCLES`. A `last` pointer (2 bits) records the previous owner.
- **IDLE:**
  - If `req` is nonzero, select the first set bit scanning `last+1`, `last+2`, … cyclically.
  - Set `grant` to that bit, `owner` to its index, and `last` to its index.
  - Clear the hold counter and go to OWNED.
- **OWNED:**
  - Each cycle, `hex_out` is loaded with `data[owner]`, so a live value change is displayed.
  - The hold counter increments and saturates at `HOLD_CYCLES`.
- **Owner drops `req`:** `grant` clears next cycle and the FSM goes to IDLE, regardless of the hold count.
- **Preemption:** when the counter equals `HOLD_CYCLES` and any other `req` bit is set, hand off directly to the next requester in round-robin order after the current owner. There is no IDLE cycle in between, and the counter clears.
- **Counter saturated, no competing request:** the owner keeps the display indefinitely.
- **Sole requester:** a lone requester is never preempted.
- **Simultaneous owner drop and competing request:** the drop wins. The FSM passes through IDLE for one cycle, then re-arbitrates.
- **In IDLE:** `hex_out` holds its last loaded value, subject to the Configuration section.
- **Reset values:**
  - `grant` = 0, `owner` = 0, `busy` = 0, `hex_out` = 24'h000000, `blank` = 1 with the macro or 0 without.
  - `last` = 3, so requester 0 wins the first tie.
  - Hold counter = 0, state = IDLE.
- **Reset mid-operation:** all of the above apply immediately. `grant` deasserts asynchronously.

## Timing
- All outputs are registered.
- A `req` rising in cycle t gives `grant` and `busy` high in cycle t+1.
- `hex_out` equals `data[owner]` as sampled at edge t+2, i.e. it is valid one cycle after grant. From then on it tracks data with a one-cycle delay.
- Preemption: the `grant` change occurs at the edge after the counter has reached `HOLD_CYCLES` with a competitor pending. `hex_out` changes one cycle later.
- A `req` drop in cycle t gives `grant` = 0 in cycle t+1. The earliest regrant is t+2.
- The round-robin pointer updates only on a grant, never on a release.

## Configuration
- Macro: `HEXARB_IDLE_BLANK_EN`.
- **Defined:**
  - In IDLE, `hex_out` is driven to 24'h000000 and `blank` = 1.
  - In OWNED, `blank` = 0.
  - `blank` changes in the same cycle as `busy`.
- **Undefined:**
  - `blank` is tied to 0.
  - In IDLE, `hex_out` retains the last owner's final value, so the display freezes rather than going dark.

## Test plan
All scenarios use `HOLD_CYCLES` = 4.
1. **Reset and first grant:** reset, then `req` = 4'b0001 with `data0` = 24'h123456. Expect `grant` = 0001 one cycle later and `hex_out` = 24'h123456 one cycle after that. `owner` = 0 and `busy` = 1.
2. **Round-robin tie:** after reset, `req` = 4'b1010. Expect `grant` = 0010. Then drop `req[1]`. Expect IDLE for one cycle, then `grant` = 1000.
3. **Preemption after hold:** owner 0 is granted, and `req[2]` rises one cycle later with `data2` = 24'hABCDEF. Expect `grant` = 0001 until the counter reaches 4, then `grant` = 0100 with no idle gap. `hex_out` = 24'hABCDEF one cycle after that.
4. **Sole requester:** `req` = 4'b0001 held for 100 cycles. Expect `grant` to stay 0001 throughout. Changing `data0` to 24'h000FFF mid-hold gives `hex_out` = 24'h000FFF one cycle later.
5. **Simultaneous drop and competitor:** at the hold boundary, `req` goes from 0001 to 0010 in one cycle. Expect `grant` = 0000 for one cycle, then 0010.
6. **Reset mid-operation and idle behaviour:**
   - Assert `reset_n` = 0 while `grant` = 0100. Expect `grant` = 0 and `hex_out` = 0 asynchronously.
   - After reset, with all `req` = 0: with the macro defined, expect `blank` = 1 and `hex_out` = 0.
   - Without the macro, after a release, expect `hex_out` to keep the last value and `blank` = 0.
